// File: rtl/adc_lvds_pkg.sv
// Shared encodings for the LVDS ADC transmit model: link modes, FSM states, PRBS-9 constants.
package adc_lvds_pkg;

    typedef enum logic [1:0] {
        MODE_DATA   = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_DESKEW = 2'd2,
        MODE_SYNC   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [8:0]  PRBS9_SEED   = 9'h1FF;
    localparam int unsigned PRBS9_TAP_HI = 8;
    localparam int unsigned PRBS9_TAP_LO = 4;

    // x^9 + x^5 + 1; the outgoing bit is the current state MSB.
    function automatic logic [8:0] prbs9_step(input logic [8:0] s);
        return {s[7:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
    endfunction

endpackage

// File: rtl/adc_lvds_tx_lane.sv
// One serial lane: frame-source mux, held-sample register and MSB-first shift register.
module adc_lvds_tx_lane
    import adc_lvds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter bit          INVERT_SYNC = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  mode_e                 i_mode,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_ramp,
    input  logic [DATA_WIDTH-1:0] i_sync_word,
    output logic                  o_dout
);

    localparam logic [DATA_WIDTH-1:0] DESKEW_WORD = {(DATA_WIDTH/2){2'b10}};

    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_held;
    logic [DATA_WIDTH-1:0] w_frame;

    always_comb begin
        w_frame = r_held;
        unique case (i_mode)
            MODE_DATA:   w_frame = i_valid ? i_sample : r_held;
            MODE_RAMP:   w_frame = i_ramp;
            MODE_DESKEW: w_frame = DESKEW_WORD;
            MODE_SYNC:   w_frame = i_sync_word ^ {DATA_WIDTH{INVERT_SYNC}};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_held  <= '0;
        end else begin
            if (i_load && (i_mode == MODE_DATA) && i_valid)
                r_held <= i_sample;
            // Shifting zeros in leaves the register empty once the last bit is out.
            if (i_load)
                r_shift <= w_frame;
            else if (i_shift)
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign o_dout = r_shift[DATA_WIDTH-1];

endmodule

// File: rtl/adc_lvds_tx.sv
// LVDS ADC link transmitter: SDR serializer with frame clock, test patterns and underflow tracking.
// Define ADC_LVDS_TX_PRBS_EN to send PRBS-9 in mode 3 instead of the sync word.
module adc_lvds_tx
    import adc_lvds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned UFLOW_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            en,
    input  logic [1:0]                      mode,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NUM_LANES-1:0]            dout,
    output logic                            fclk,
    output logic                            underflow,
    output logic [UFLOW_CNT_W-1:0]          underflow_cnt
);

    localparam int unsigned    CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DATA_WIDTH / 2);

    state_e                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt, w_bit_cnt_inc;
    logic                   r_fclk, w_fclk_nxt;
    logic                   w_load;
    logic                   w_starve;
    logic [DATA_WIDTH-1:0]  r_ramp;
    logic                   r_underflow;
    logic [UFLOW_CNT_W-1:0] r_uflow_cnt;
    logic [DATA_WIDTH-1:0]  w_sync_word;
    mode_e                  w_mode;

    assign w_mode        = mode_e'(mode);
    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_fclk    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_fclk    <= w_fclk_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = '0;
        w_fclk_nxt    = 1'b0;
        w_load        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                    w_fclk_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (r_bit_cnt == LAST) begin
                    if (en) begin
                        w_load     = 1'b1;
                        w_fclk_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = w_bit_cnt_inc;
                    w_fclk_nxt    = (w_bit_cnt_inc < HALF);
                end
            end
        endcase
    end

    // Gated with reset so the handshake reads idle while reset is held, whatever en does.
    assign s_ready  = w_load & reset_n;
    assign w_starve = w_load && (w_mode == MODE_DATA) && !s_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ramp      <= '0;
            r_underflow <= 1'b0;
            r_uflow_cnt <= '0;
        end else begin
            if (w_load && (w_mode == MODE_RAMP))
                r_ramp <= r_ramp + 1'b1;
            r_underflow <= w_starve;
            if (w_starve && (r_uflow_cnt != '1))
                r_uflow_cnt <= r_uflow_cnt + 1'b1;
        end
    end

`ifdef ADC_LVDS_TX_PRBS_EN
    logic [8:0] r_prbs, w_prbs_walk;

    // Whole frame of PRBS bits is unrolled at load time; equivalent to one step per bit.
    always_comb begin
        w_prbs_walk = r_prbs;
        w_sync_word = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            w_sync_word[DATA_WIDTH-1-i] = w_prbs_walk[PRBS9_TAP_HI];
            w_prbs_walk                 = prbs9_step(w_prbs_walk);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_prbs <= PRBS9_SEED;
        else if (w_load && (w_mode == MODE_SYNC))
            r_prbs <= w_prbs_walk;
    end
`else
    assign w_sync_word = {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};
`endif

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
`ifdef ADC_LVDS_TX_PRBS_EN
        localparam bit LANE_INV = bit'(n % 2);
`else
        localparam bit LANE_INV = 1'b0;
`endif
        adc_lvds_tx_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .INVERT_SYNC (LANE_INV)
        ) u_lane (
            .i_clk       (clk),
            .i_rst_n     (reset_n),
            .i_load      (w_load),
            .i_shift     (r_state == RUN),
            .i_mode      (w_mode),
            .i_sample    (s_data[n*DATA_WIDTH +: DATA_WIDTH]),
            .i_valid     (s_valid),
            .i_ramp      (r_ramp),
            .i_sync_word (w_sync_word),
            .o_dout      (dout[n])
        );
    end

    assign fclk          = r_fclk;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_uflow_cnt;

endmodule

// File: tb/tb_adc_lvds_tx.sv
// Scoreboard bench for adc_lvds_tx: expected frames queued at accept, compared as they leave the lanes.
module tb_adc_lvds_tx;

    localparam int DW = 14;
    localparam int NL = 2;
    localparam int UW = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [NL*DW-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [NL-1:0]    dout;
    logic             fclk;
    logic             underflow;
    logic [UW-1:0]    underflow_cnt;

    adc_lvds_tx #(
        .DATA_WIDTH  (DW),
        .NUM_LANES   (NL),
        .UFLOW_CNT_W (UW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .mode          (mode),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .dout          (dout),
        .fclk          (fclk),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
    } frame_t;

    frame_t sb[$];
    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_held0 = '0, m_held1 = '0, m_ramp = '0;
    logic [8:0]    m_prbs = 9'h1FF;
    logic [UW-1:0] m_ucnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: a frame starts on the first cycle fclk is seen high.
    logic          mon_busy = 1'b0;
    int            mon_idx = 0;
    logic [DW-1:0] g0, g1;

    always @(negedge clk) begin
        if (!reset_n) begin
            if (mon_busy && sb.size() > 0) void'(sb.pop_front());
            mon_busy = 1'b0;
        end else if (mon_busy || fclk) begin
            frame_t e;
            if (!mon_busy) begin
                mon_busy = 1'b1;
                mon_idx  = 0;
            end
            check("fclk", 32'(fclk), 32'(mon_idx < DW/2));
            if (mon_idx != 0) check("uflow_width", 32'(underflow), 0);
            g0[DW-1-mon_idx] = dout[0];
            g1[DW-1-mon_idx] = dout[1];
            mon_idx++;
            if (mon_idx == DW) begin
                mon_busy = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underrun", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("lane0", 32'(g0), 32'(e.w0));
                    check("lane1", 32'(g1), 32'(e.w1));
                end
            end
        end else begin
            check("idle_dout", 32'(dout), 0);
        end
    end

    task automatic send_frame(input logic [1:0] m, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic v, output int waits);
        frame_t        f;
        logic          uf;
        logic [DW-1:0] w;
        @(negedge clk);
        en = 1'b1; mode = m; s_data = {d1, d0}; s_valid = v;
        waits = 0;
        #1;
        while (!s_ready && waits < 40) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!s_ready) begin
            check("ready_timeout", 32'(s_ready), 1);
            return;
        end
        uf = 1'b0;
        w  = '0;
        case (m)
            2'd0: begin
                if (v) begin
                    m_held0 = d0; m_held1 = d1;
                end else begin
                    uf = 1'b1;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end
                f.w0 = m_held0; f.w1 = m_held1;
            end
            2'd1: begin
                f.w0 = m_ramp; f.w1 = m_ramp;
                m_ramp++;
            end
            2'd2: begin
                f.w0 = 14'h2AAA; f.w1 = 14'h2AAA;
            end
            default: begin
`ifdef ADC_LVDS_TX_PRBS_EN
                for (int i = DW - 1; i >= 0; i--) begin
                    w[i]   = m_prbs[8];
                    m_prbs = {m_prbs[7:0], m_prbs[8] ^ m_prbs[4]};
                end
                f.w0 = w; f.w1 = ~w;
`else
                f.w0 = 14'h3F80; f.w1 = 14'h3F80;
`endif
            end
        endcase
        sb.push_back(f);
        @(posedge clk); #1;
        check("underflow", 32'(underflow), 32'(uf));
        check("uflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    task automatic stop_tx();
        @(negedge clk);
        en = 1'b0;
        drain();
    endtask

    initial begin
        int w;
        #3;
        en = 1'b1;
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_fclk", 32'(fclk), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_uflow", 32'(underflow), 0);
        check("rst_ucnt", 32'(underflow_cnt), 0);
        en = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        send_frame(2'd0, 14'h2C35, 14'h0001, 1'b1, w);
        check("ready_idle", 32'(w), 0);
        send_frame(2'd0, 14'h3333, 14'h3333, 1'b0, w);
        check("ready_gap", 32'(w), 13);
        stop_tx();

        force dut.r_uflow_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_uflow_cnt;
        m_ucnt = 16'hFFFE;
        send_frame(2'd0, 14'h0F0F, 14'h0F0F, 1'b0, w);
        send_frame(2'd0, 14'h0F0F, 14'h0F0F, 1'b0, w);
        stop_tx();

        send_frame(2'd1, 14'h1111, 14'h2222, 1'b1, w);
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("off_ready", 32'(s_ready), 0);
            check("off_fclk", 32'(fclk), 0);
            check("off_dout", 32'(dout), 0);
        end
        send_frame(2'd1, 14'h1111, 14'h2222, 1'b1, w);
        check("ready_restart", 32'(w), 0);
        send_frame(2'd1, 14'h1111, 14'h2222, 1'b1, w);
        stop_tx();

        force dut.r_ramp = 14'h3FFF;
        @(negedge clk);
        release dut.r_ramp;
        m_ramp = 14'h3FFF;
        send_frame(2'd1, 14'h0000, 14'h0000, 1'b1, w);
        send_frame(2'd1, 14'h0000, 14'h0000, 1'b1, w);
        send_frame(2'd2, 14'h1234, 14'h1234, 1'b1, w);
        send_frame(2'd3, 14'h1234, 14'h1234, 1'b1, w);
        send_frame(2'd3, 14'h1234, 14'h1234, 1'b1, w);
        send_frame(2'd0, 14'h0000, 14'h0000, 1'b0, w);
        stop_tx();

        send_frame(2'd0, 14'h1234, 14'h0567, 1'b1, w);
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_dout", 32'(dout), 0);
        check("mid_rst_fclk", 32'(fclk), 0);
        check("mid_rst_ready", 32'(s_ready), 0);
        check("mid_rst_ucnt", 32'(underflow_cnt), 0);
        en = 1'b0;
        m_held0 = '0; m_held1 = '0; m_ramp = '0; m_prbs = 9'h1FF; m_ucnt = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        send_frame(2'd0, 14'h2C35, 14'h0001, 1'b1, w);
        check("ready_after_rst", 32'(w), 0);
        stop_tx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
